// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator control path: ALU op codes,
// sequencer states, active-low status LED patterns and the op-button priority
// encoder used when several op buttons are accepted in the same cycle.
// -----------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      PLUS = 2'd0,
      SUB  = 2'd1,
      MUL  = 2'd2,
      DIV  = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      HAVE_A,
      HAVE_B,
      EXEC,
      SHOW
   } state_t;

   // Active-low LED patterns: exactly one LED lit per phase.
   localparam logic [2:0] LED_IDLE = 3'b110;
   localparam logic [2:0] LED_A    = 3'b101;
   localparam logic [2:0] LED_B    = 3'b011;

   // Lowest-index op wins: plus > minus > mult > div.
   function automatic op_t lowest_op(input logic [3:0] press);
      if (press[0])      return PLUS;
      else if (press[1]) return SUB;
      else if (press[2]) return MUL;
      else               return DIV;
   endfunction

endpackage

// File: rtl/calc_if.sv
// -----------------------------------------------------------------------------
// calc_if
// Handshake between the calculator sequencer and the arithmetic unit.
//   operand_a/operand_b : latched operands (sequencer -> ALU)
//   alu_op              : op code, held from alu_start until alu_done
//   alu_start           : one-cycle launch pulse
//   alu_done            : one-cycle pulse, result valid (ALU -> sequencer)
//   alu_error           : qualified by alu_done
// Modports: master = sequencer side, slave = ALU side.
// -----------------------------------------------------------------------------
interface calc_if
   import calc_pkg::*;
#(
   parameter int IN_WIDTH = 4
) ();

   logic [IN_WIDTH-1:0] operand_a;
   logic [IN_WIDTH-1:0] operand_b;
   op_t                 alu_op;
   logic                alu_start;
   logic                alu_done;
   logic                alu_error;

   modport master (
      output operand_a, operand_b, alu_op, alu_start,
      input  alu_done, alu_error
   );

   modport slave (
      input  operand_a, operand_b, alu_op, alu_start,
      output alu_done, alu_error
   );

endinterface

// File: rtl/calc_debounce.sv
// -----------------------------------------------------------------------------
// calc_debounce
// Debouncer for one active-low push button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_ni     : raw button level, active-low, asynchronous to clk
//   press_o    : one-cycle pulse on the debounced high-to-low edge
//   release_o  : one-cycle pulse on the debounced low-to-high edge
// The raw level is 2-FF synchronised; the debounced level follows only after
// DEBOUNCE_CYCLES consecutive samples that differ from it. Press-to-pulse
// latency is 2 + DEBOUNCE_CYCLES cycles.
// -----------------------------------------------------------------------------
module calc_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_ni,
   output logic press_o,
   output logic release_o
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every variable gets its default before any branch; a path that
   // leaves a combinational output unassigned would infer a latch.
   always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // Last differing sample of the run: accept the new level. The count
         // stops here, so it never wraps.
         cnt_d     = '0;
         level_d   = sync2_q;
         press_d   = ~sync2_q;
         release_d = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the pre-edge value of the others (the sync chain depends on it).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         level_q   <= 1'b1;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_ni;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Control FSM of the calculator datapath.
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_number_i   : operand switches, active-low (operand = ~in_number_i)
//   key_i[1:0]    : enter buttons, active-low; [0]=enter A, [1]=enter B
//   arif_i[3:0]   : op buttons, active-low; [0]=+ [1]=- [2]=* [3]=/
//   alu           : calc_if.master (operands, op, start / done, error)
//   disp_sel_o    : 0 = live input, 1 = result
//   disp_error_o  : display shows "E"
//   disp_point_o  : decimal point for the x100-scaled division result
//   led_o[2:0]    : active-low status LEDs
// -----------------------------------------------------------------------------
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int IN_WIDTH        = 4,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int ALU_TIMEOUT     = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IN_WIDTH-1:0] in_number_i,
   input  logic [1:0]          key_i,
   input  logic [3:0]          arif_i,
   calc_if.master              alu,
   output logic                disp_sel_o,
   output logic                disp_error_o,
   output logic                disp_point_o,
   output logic [2:0]          led_o
);

   localparam int            TW           = $clog2(ALU_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ALU_TIMEOUT - 1);

   logic [1:0] key_press, key_release_unused;
   logic [3:0] op_press, op_release;

   for (genvar i = 0; i < 2; i++) begin : g_key_db
      calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_ni    (key_i[i]),
         .press_o   (key_press[i]),
         .release_o (key_release_unused[i])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_op_db
      calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_ni    (arif_i[i]),
         .press_o   (op_press[i]),
         .release_o (op_release[i])
      );
   end

   state_t              state_q, state_d;
   logic [IN_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   op_t                 alu_op_q, alu_op_d;
   logic                start_q, start_d;
   logic                sel_q, sel_d, err_q, err_d, point_q, point_d;
   logic [2:0]          led_q, led_d;
   logic [TW-1:0]       timer_q, timer_d;
   op_t                 new_op;

   assign new_op = lowest_op(op_press);

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      alu_op_d = alu_op_q;
      start_d  = 1'b0;
      sel_d    = sel_q;
      err_d    = err_q;
      point_d  = point_q;
      led_d    = led_q;
      timer_d  = timer_q;

      case (state_q)
         EXEC: begin
            // Buttons are deliberately ignored while the ALU is busy.
            timer_d = timer_q + 1'b1;
            if (alu.alu_done) begin
               state_d = SHOW;
               sel_d   = 1'b1;
               err_d   = alu.alu_error;
               point_d = (alu_op_q == DIV) && !alu.alu_error;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d = SHOW;
               sel_d   = 1'b1;
               err_d   = 1'b1;
               point_d = 1'b0;
            end
         end
         default: begin
            // Priority: enter A, then enter B, then op press, then release.
            if (key_press[0]) begin
               op_a_d  = ~in_number_i;
               led_d   = LED_A;
               state_d = HAVE_A;
               sel_d   = 1'b0;
               err_d   = 1'b0;
               point_d = 1'b0;
            end else if (key_press[1] && (state_q == HAVE_A || state_q == HAVE_B)) begin
               op_b_d  = ~in_number_i;
               led_d   = LED_B;
               state_d = HAVE_B;
            end else if (state_q == HAVE_B && |op_press) begin
               alu_op_d = new_op;
               led_d    = LED_IDLE;
               if (new_op == DIV && op_b_q == '0) begin
                  // Division by zero never reaches the ALU.
                  state_d = SHOW;
                  sel_d   = 1'b1;
                  err_d   = 1'b1;
                  point_d = 1'b0;
               end else begin
                  start_d = 1'b1;
                  timer_d = '0;
                  state_d = EXEC;
               end
            end else if (state_q == SHOW && op_release[alu_op_q]) begin
               // Operands stay latched so a new op press recomputes.
               state_d = HAVE_B;
               sel_d   = 1'b0;
               err_d   = 1'b0;
               point_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         alu_op_q <= PLUS;
         start_q  <= 1'b0;
         sel_q    <= 1'b0;
         err_q    <= 1'b0;
         point_q  <= 1'b0;
         led_q    <= LED_IDLE;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         alu_op_q <= alu_op_d;
         start_q  <= start_d;
         sel_q    <= sel_d;
         err_q    <= err_d;
         point_q  <= point_d;
         led_q    <= led_d;
         timer_q  <= timer_d;
      end
   end

   assign alu.operand_a = op_a_q;
   assign alu.operand_b = op_b_q;
   assign alu.alu_op    = alu_op_q;
   assign alu.alu_start = start_q;
   assign disp_sel_o    = sel_q;
   assign disp_error_o  = err_q;
   assign disp_point_o  = point_q;
   assign led_o         = led_q;

endmodule
